dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter_arb_rr2.sv | 12 +
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // Access length in cycles; the down-counter is sized for the largest legal value.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory signals of the data-memory arbiter, bundled as one interface.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  // Handshake: a requester raises reqN with weN/addrN/wdataN stable and may drop it any
  // time; a latched access always completes with a single-cycle ackN, and reqN seen in a
  // cycle where ackN is high is ignored so the requester can withdraw after its ack.
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              gnt0, gnt1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, gnt0, gnt1, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, gnt0, gnt1, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/dmem_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the port not granted last wins.
module arb_rr2 (
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  assign valid  = |eligible;
  assign winner = (&eligible) ? ~last : eligible[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory. Each granted
// access holds the memory for LAT cycles and ends with a one-cycle ack to its owner.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int LAT    = 2
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output state_e        state_o
);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("dmem_arbiter: LAT=%0d outside legal range", LAT);
  end

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] eligible;
  logic       pick_valid;
  logic       pick_winner;

  // A port whose ack is high this cycle is just finishing and must not re-win.
  assign eligible = {bus.req1 & ~ack_q[1], bus.req0 & ~ack_q[0]};

  arb_rr2 u_rr (
    .eligible (eligible),
    .last     (last_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_BUSY;
          owner_d = pick_winner;
          cnt_d   = LAT_M1;
          we_d    = pick_winner ? bus.we1    : bus.we0;
          addr_d  = pick_winner ? bus.addr1  : bus.addr0;
          wdata_d = pick_winner ? bus.wdata1 : bus.wdata0;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d[owner_q] = 1'b1;
          if (!we_q) begin
            if (owner_q == PORT_HOST) rdata1_d = bus.mem_rdata;
            else                      rdata0_d = bus.mem_rdata;
          end
          last_d  = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      owner_q  <= PORT_CORE;
      last_q   <= PORT_HOST;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory strobes and grants are pure decodes of the registered state, so they drop
  // in the first cycle after a reset edge.
  assign bus.gnt0      = (state_q == ST_BUSY) && (owner_q == PORT_CORE);
  assign bus.gnt1      = (state_q == ST_BUSY) && (owner_q == PORT_HOST);
  assign bus.mem_we    = (state_q == ST_BUSY) &&  we_q;
  assign bus.mem_re    = (state_q == ST_BUSY) && !we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (LAT=1,2,3) share one stimulus stream and are
// compared every cycle against a transaction-level model, plus directed scenario checks.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW   = 64;
  localparam int AW   = 64;
  localparam int NI   = 3;
  localparam int WIDE = 7 + AW + 3 * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic [NI-1:0][1:0]    obs_ack, obs_gnt;
  logic [NI-1:0]         obs_we, obs_re, obs_st;
  logic [NI-1:0][AW-1:0] obs_maddr;
  logic [NI-1:0][DW-1:0] obs_mwdata, obs_rd0, obs_rd1, obs_m20, obs_m28;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 2) return 64'h0000_0000_DEAD_BEEF;
    return {32'hC0DE_0000, 32'(i)};
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_inst
    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    logic [DW-1:0] mem [32];
    state_e        dbg_state;

    assign bus.req0      = req0;
    assign bus.req1      = req1;
    assign bus.we0       = we0;
    assign bus.we1       = we1;
    assign bus.addr0     = addr0;
    assign bus.addr1     = addr1;
    assign bus.wdata0    = wdata0;
    assign bus.wdata1    = wdata1;
    assign bus.mem_rdata = mem[bus.mem_addr[7:3]];

    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      end else if (bus.mem_we) begin
        mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
      end
    end

    assign obs_ack[k]    = {bus.ack1, bus.ack0};
    assign obs_gnt[k]    = {bus.gnt1, bus.gnt0};
    assign obs_we[k]     = bus.mem_we;
    assign obs_re[k]     = bus.mem_re;
    assign obs_st[k]     = (dbg_state == ST_BUSY);
    assign obs_maddr[k]  = bus.mem_addr;
    assign obs_mwdata[k] = bus.mem_wdata;
    assign obs_rd0[k]    = bus.rdata0;
    assign obs_rd1[k]    = bus.rdata1;
    assign obs_m20[k]    = mem[4];
    assign obs_m28[k]    = mem[5];

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LAT(k + 1)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .state_o (dbg_state)
    );
  end

  // Reference model: one record per instance describing the access in flight.
  logic          m_busy [NI];
  logic          m_owner[NI];
  logic          m_last [NI];
  logic          m_we   [NI];
  logic [AW-1:0] m_addr [NI];
  logic [DW-1:0] m_wdata[NI];
  int            m_done [NI];
  logic [1:0]    m_ack  [NI];
  logic [DW-1:0] m_rd0  [NI];
  logic [DW-1:0] m_rd1  [NI];
  logic [DW-1:0] m_mem  [NI][32];
  int            cyc;

  int n_checks = 0;
  int n_errors = 0;

  int ack_cnt[NI][2];
  int re_cyc [NI];
  int gseq1[$];
  int gap1[$];
  int ackpos0[$];
  int idle_run1, viol0;
  logic seen_busy1;
  logic [1:0] prev_gnt1, prev_gnt0;
  logic prev_ack0;

  task automatic check(input string tag, input logic [WIDE-1:0] got, input logic [WIDE-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      logic [1:0] nack;
      logic [1:0] elig;
      if (reset) begin
        m_busy[k] = 1'b0;  m_owner[k] = 1'b0; m_last[k] = 1'b1; m_we[k] = 1'b0;
        m_addr[k] = '0;    m_wdata[k] = '0;   m_ack[k]  = 2'b00;
        m_rd0[k]  = '0;    m_rd1[k]   = '0;   m_done[k] = 0;
        for (int i = 0; i < 32; i++) m_mem[k][i] = init_word(i);
      end else begin
        nack = 2'b00;
        elig = {req1 & ~m_ack[k][1], req0 & ~m_ack[k][0]};
        if (m_busy[k]) begin
          if (m_we[k]) m_mem[k][m_addr[k][7:3]] = m_wdata[k];
          if (cyc == m_done[k]) begin
            nack[m_owner[k]] = 1'b1;
            if (!m_we[k]) begin
              if (m_owner[k]) m_rd1[k] = m_mem[k][m_addr[k][7:3]];
              else            m_rd0[k] = m_mem[k][m_addr[k][7:3]];
            end
            m_last[k] = m_owner[k];
            m_busy[k] = 1'b0;
          end
        end else if (elig != 2'b00) begin
          if (elig == 2'b11) m_owner[k] = (m_last[k] == 1'b1) ? 1'b0 : 1'b1;
          else               m_owner[k] = (elig == 2'b10);
          m_busy[k]  = 1'b1;
          m_we[k]    = m_owner[k] ? we1    : we0;
          m_addr[k]  = m_owner[k] ? addr1  : addr0;
          m_wdata[k] = m_owner[k] ? wdata1 : wdata0;
          m_done[k]  = cyc + k + 1;
        end
        m_ack[k] = nack;
      end
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < NI; k++) begin
      ack_cnt[k][0] = 0; ack_cnt[k][1] = 0; re_cyc[k] = 0;
    end
    gseq1.delete(); gap1.delete(); ackpos0.delete();
    idle_run1 = 0; viol0 = 0; seen_busy1 = 1'b0;
    prev_gnt1 = 2'b00; prev_gnt0 = 2'b00; prev_ack0 = 1'b0;
  endtask

  task automatic step();
    logic [WIDE-1:0] got_v, exp_v;
    logic [1:0]      eg;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < NI; k++) begin
      eg    = m_busy[k] ? (m_owner[k] ? 2'b10 : 2'b01) : 2'b00;
      exp_v = {m_ack[k], eg, m_busy[k] & m_we[k], m_busy[k] & ~m_we[k], m_busy[k],
               m_addr[k], m_wdata[k], m_rd0[k], m_rd1[k]};
      got_v = {obs_ack[k], obs_gnt[k], obs_we[k], obs_re[k], obs_st[k],
               obs_maddr[k], obs_mwdata[k], obs_rd0[k], obs_rd1[k]};
      check($sformatf("cyc%0d_lat%0d", cyc, k + 1), got_v, exp_v);
      if (obs_ack[k][0]) ack_cnt[k][0]++;
      if (obs_ack[k][1]) ack_cnt[k][1]++;
      if (obs_re[k])     re_cyc[k]++;
    end
    if (obs_gnt[1] != 2'b00 && prev_gnt1 == 2'b00) begin
      gseq1.push_back(int'(obs_gnt[1][1]));
      if (seen_busy1) gap1.push_back(idle_run1);
      seen_busy1 = 1'b1;
    end
    if (obs_gnt[1] == 2'b00) idle_run1++;
    else                     idle_run1 = 0;
    if (obs_ack[0][0]) ackpos0.push_back(cyc);
    if (obs_gnt[0] != 2'b00 && prev_gnt0 == 2'b00 && prev_ack0) viol0++;
    prev_gnt1 = obs_gnt[1];
    prev_gnt0 = obs_gnt[0];
    prev_ack0 = obs_ack[0][0];
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step();
    step();
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic wait_ack(input int k, input int port, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!obs_ack[k][port] && n < 40);
    check(tag, WIDE'(obs_ack[k][port]), WIDE'(1));
  endtask

  task automatic wait_gnt(input int k, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (obs_gnt[k] == 2'b00 && n < 40);
    check(tag, WIDE'(obs_gnt[k] != 2'b00), WIDE'(1));
  endtask

  function automatic logic [5:0] seq_bits(input int n);
    logic [5:0] b;
    b = '0;
    for (int i = 0; i < n && i < 6 && i < gseq1.size(); i++) b[i] = gseq1[i][0];
    return b;
  endfunction

  initial begin
    int bad;
    int gmin, gmax;
    cyc = 0;

    // Reset state
    do_reset();
    for (int k = 0; k < NI; k++)
      check($sformatf("reset_state_lat%0d", k + 1),
            WIDE'({obs_ack[k], obs_gnt[k], obs_we[k], obs_re[k], obs_st[k],
                   obs_maddr[k], obs_mwdata[k], obs_rd0[k], obs_rd1[k]}), WIDE'(0));

    // Single read on port 0 (LAT=2 instance)
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    wait_ack(1, 0, "r33_ack_seen");
    req0 = 1'b0;
    repeat (3) step();
    check("r33_ack_count", WIDE'(ack_cnt[1][0]), WIDE'(1));
    check("r33_re_cycles", WIDE'(re_cyc[1]), WIDE'(2));
    check("r33_rdata0", WIDE'(obs_rd0[1]), WIDE'(64'hDEAD_BEEF));
    check("r33_rdata1", WIDE'(obs_rd1[1]), WIDE'(0));

    // Simultaneous write/read to the same word right after reset
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h8; wdata0 = 64'h55;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h8;
    wait_ack(1, 0, "r34_ack0_seen");
    req0 = 1'b0;
    wait_ack(1, 1, "r34_ack1_seen");
    req1 = 1'b0;
    repeat (3) step();
    check("r34_rdata1", WIDE'(obs_rd1[1]), WIDE'(64'h55));
    check("r34_order_len", WIDE'(gseq1.size()), WIDE'(2));
    check("r34_order", WIDE'(seq_bits(2)), WIDE'(6'b000010));

    // Sustained contention for six transactions
    do_reset();
    req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = AW'(8 * $urandom_range(0, 31));
    wdata0 = {$urandom, $urandom};
    req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = AW'(8 * $urandom_range(0, 31));
    wdata1 = {$urandom, $urandom};
    for (int t = 0; t < 6; t++) wait_ack(1, t % 2, $sformatf("r35_ack_%0d", t));
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) step();
    check("r35_order_len", WIDE'(gseq1.size()), WIDE'(6));
    check("r35_order", WIDE'(seq_bits(6)), WIDE'(6'b101010));
    check("r35_gap_count", WIDE'(gap1.size()), WIDE'(5));
    gmin = 99; gmax = -1;
    foreach (gap1[i]) begin
      if (gap1[i] < gmin) gmin = gap1[i];
      if (gap1[i] > gmax) gmax = gap1[i];
    end
    check("r35_gap_min", WIDE'(gmin), WIDE'(1));
    check("r35_gap_max", WIDE'(gmax), WIDE'(1));

    // Address change after the grant edge must not redirect the write
    do_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'h20; wdata1 = 64'h1;
    wait_gnt(1, "r36_gnt_seen");
    addr1 = 64'h28; wdata1 = 64'hFFFF;
    wait_ack(1, 1, "r36_ack_seen");
    req1 = 1'b0;
    repeat (3) step();
    check("r36_mem20", WIDE'(obs_m20[1]), WIDE'(64'h1));
    check("r36_mem28", WIDE'(obs_m28[1]), WIDE'(init_word(5)));
    check("r36_ack_count", WIDE'(ack_cnt[1][1]), WIDE'(1));

    // Reset in the first BUSY cycle of a write (LAT=3 instance)
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h30; wdata0 = {$urandom, $urandom};
    step();
    check("r37_we_busy", WIDE'(obs_we[2]), WIDE'(1));
    reset = 1'b1; req0 = 1'b0;
    step();
    reset = 1'b0;
    check("r37_outputs_zero",
          WIDE'({obs_ack[2], obs_gnt[2], obs_we[2], obs_re[2], obs_st[2],
                 obs_maddr[2], obs_mwdata[2], obs_rd0[2], obs_rd1[2]}), WIDE'(0));
    repeat (4) step();
    check("r37_no_ack", WIDE'(ack_cnt[2][0] + ack_cnt[2][1]), WIDE'(0));
    req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
    step();
    check("r37_tie_port0", WIDE'(obs_gnt[2]), WIDE'(2'b01));
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) step();

    // LAT=1 with req0 held continuously
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(8 * $urandom_range(0, 31));
    repeat (30) step();
    req0 = 1'b0;
    check("r38_ack_count", WIDE'(ack_cnt[0][0]), WIDE'(10));
    bad = 0;
    for (int i = 1; i < ackpos0.size(); i++)
      if (ackpos0[i] - ackpos0[i-1] != 3) bad++;
    check("r38_ack_period", WIDE'(bad), WIDE'(0));
    check("r38_no_resample", WIDE'(viol0), WIDE'(0));
    repeat (3) step();

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 2) == 0) req1 = ~req1;
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = AW'(8 * $urandom_range(0, 31));
      addr1  = AW'(8 * $urandom_range(0, 31));
      wdata0 = {$urandom, $urandom};
      wdata1 = {$urandom, $urandom};
      reset  = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
